// File: rtl/note_osc.sv
// note_osc
// Sample-rate oscillator feeding the ADSR envelope stage. A phase accumulator
// advances once per sample tick and its top 16 bits are mapped to a square,
// saw or triangle wave (or silence). The note_on level is turned into a gate,
// and after release the oscillator keeps running for RELEASE_SAMPLES ticks so
// the envelope release tail still has signal to shape.
//
// Ports:
//   clk        in   1        system clock, rising edge
//   reset      in   1        asynchronous active-high reset
//   phase_inc  in   PHASE_W  per-sample phase increment (pitch), used on tick
//   wave_sel   in   2        0 square, 1 saw, 2 triangle, 3 silence, used on tick
//   note_on    in   1        note level from keyboard/sequencer
//   sample_out out  16       signed sample, two's complement
//   out_ready  out  1        one-cycle strobe marking a new sample_out
//   gate       out  1        high while the note is held

module note_osc #(
    parameter int SAMPLE_DIV      = 2083,
    parameter int PHASE_W         = 24,
    parameter int RELEASE_SAMPLES = 4800
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PHASE_W-1:0]  phase_inc,
    input  logic [1:0]          wave_sel,
    input  logic                note_on,
    output logic signed [15:0]  sample_out,
    output logic                out_ready,
    output logic                gate
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int REL_W = $clog2(RELEASE_SAMPLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [DIV_W-1:0]      div_cnt;
    logic [PHASE_W-1:0]    phase, phase_next;
    logic [REL_W-1:0]      rel_cnt, rel_next;
    logic signed [15:0]    sample_next;
    logic                  note_q;
    logic                  tick;
    logic                  rise;
    logic                  fall;

    // Maps the top 16 phase bits to a waveform. The 16'h8000 xor turns an
    // unsigned ramp into a signed one; the triangle folds the ramp at the
    // half-period by inverting the doubled lower bits.
    function automatic logic [15:0] wave(input logic [15:0] p, input logic [1:0] sel);
        logic [15:0] dbl;
        dbl = {p[14:0], 1'b0};
        case (sel)
            2'd0:    wave = p[15] ? 16'h8001 : 16'h7FFF;
            2'd1:    wave = p ^ 16'h8000;
            2'd2:    wave = p[15] ? (~dbl ^ 16'h8000) : (dbl ^ 16'h8000);
            default: wave = 16'h0000;
        endcase
    endfunction

    assign tick = (div_cnt == DIV_LAST);
    assign rise = note_on & ~note_q;
    assign fall = ~note_on & note_q;

    // Free-running sample divider plus the note edge-detect register. The
    // divider never stops, so out_ready keeps pulsing even while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            out_ready <= 1'b0;
            note_q    <= 1'b0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            out_ready <= tick;
            note_q    <= note_on;
        end
    end

    // State register along with everything whose next value the FSM decides.
    // gate is registered from the next state so it changes on the same edge
    // as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            rel_cnt    <= '0;
            sample_out <= '0;
            gate       <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            rel_cnt    <= rel_next;
            sample_out <= sample_next;
            gate       <= (state_next == RUN);
        end
    end

    // Next-state logic. A tick always uses the pre-edge state to choose the
    // emitted sample, so transitions never lose or invent a sample. In HOLD
    // a retrigger takes priority over release expiry and keeps the phase so
    // the waveform has no discontinuity.
    always_comb begin
        state_next  = state;
        phase_next  = phase;
        rel_next    = rel_cnt;
        sample_next = sample_out;

        if (tick) begin
            sample_next = (state == IDLE) ? 16'sd0 : wave(phase[PHASE_W-1 -: 16], wave_sel);
        end

        case (state)
            IDLE: begin
                phase_next = '0;
                if (rise) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    phase_next = phase + phase_inc;
                end
                if (fall) begin
                    state_next = HOLD;
                    rel_next   = '0;
                end
            end
            HOLD: begin
                if (tick) begin
                    phase_next = phase + phase_inc;
                end
                if (rise) begin
                    state_next = RUN;
                    rel_next   = '0;
                end else if (tick) begin
                    if (rel_cnt == REL_LAST) begin
                        state_next = IDLE;
                        phase_next = '0;
                        rel_next   = '0;
                    end else begin
                        rel_next = rel_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_note_osc.sv
// tb_note_osc
// Directed bench for note_osc with a short divider and release window.
// Waveform vectors are table-driven; gate timing, release, retrigger,
// wrap-around, tick-only input sampling and async reset are hand sequences.

module tb_note_osc;

    localparam int SAMPLE_DIV      = 4;
    localparam int PHASE_W         = 24;
    localparam int RELEASE_SAMPLES = 3;
    localparam int NVEC            = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [PHASE_W-1:0]  phase_inc;
    logic [1:0]          wave_sel;
    logic                note_on;
    logic signed [15:0]  sample_out;
    logic                out_ready;
    logic                gate;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]         sel;
        logic [23:0]        inc;
        logic [0:7][15:0]   exp;
    } vec_t;

    vec_t vecs [NVEC];

    note_osc #(
        .SAMPLE_DIV      (SAMPLE_DIV),
        .PHASE_W         (PHASE_W),
        .RELEASE_SAMPLES (RELEASE_SAMPLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .phase_inc  (phase_inc),
        .wave_sel   (wave_sel),
        .note_on    (note_on),
        .sample_out (sample_out),
        .out_ready  (out_ready),
        .gate       (gate)
    );

    // 10 ns clock; outputs are sampled 1 ns after each rising edge.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [23:0] inc, input logic note);
        wave_sel  = sel;
        phase_inc = inc;
        note_on   = note;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Holds reset over two edges and releases it just after an edge, so the
    // divider restarts from zero with a known phase relative to the bench.
    task automatic doReset();
        reset = 1'b1;
        applyStimulus(2'd0, 24'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Waits (bounded) for the next out_ready strobe and returns the sample.
    task automatic getSample(input string name, output int value);
        bit seen;
        seen  = 1'b0;
        value = -100000;
        for (int i = 0; i < 4 * SAMPLE_DIV && !seen; i++) begin
            stepClock();
            if (out_ready) begin
                seen  = 1'b1;
                value = int'(sample_out);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: out_ready timeout, got none, expected a strobe", name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int pulses;
        int first;
        int bad;
        bit prev;

        vecs[0].sel = 2'd0; vecs[0].inc = 24'h400000;
        vecs[0].exp = {16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001};
        vecs[1].sel = 2'd2; vecs[1].inc = 24'h200000;
        vecs[1].exp = {16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'h7FFF, 16'h3FFF, 16'hFFFF, 16'hBFFF};
        vecs[2].sel = 2'd1; vecs[2].inc = 24'h100000;
        vecs[2].exp = {16'h8000, 16'h9000, 16'hA000, 16'hB000, 16'hC000, 16'hD000, 16'hE000, 16'hF000};
        vecs[3].sel = 2'd3; vecs[3].inc = 24'h100000;
        vecs[3].exp = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[4].sel = 2'd1; vecs[4].inc = 24'h123456;
        vecs[4].exp = {16'h8000, 16'h9234, 16'hA468, 16'hB69D, 16'hC8D1, 16'hDB05, 16'hED3A, 16'hFF6E};

        // Reset values while reset is held.
        reset = 1'b1;
        applyStimulus(2'd0, 24'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_sample", int'(sample_out), 0);
        checkOutput("reset_ready", int'(out_ready), 0);
        checkOutput("reset_gate", int'(gate), 0);
        reset = 1'b0;

        // Idle divider: 40 clocks, one-cycle strobes every 4 clocks, silent.
        pulses = 0; first = -1; bad = 0; prev = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            stepClock();
            if (out_ready) begin
                pulses++;
                if (first < 0) first = c;
                if (sample_out != 16'sd0) bad++;
                if (prev) bad++;
            end
            if (gate) bad++;
            prev = out_ready;
        end
        checkOutput("idle_pulses", pulses, 10);
        checkOutput("idle_first_pulse", first, 4);
        checkOutput("idle_violations", bad, 0);

        // Waveform table.
        for (int i = 0; i < NVEC; i++) begin
            doReset();
            applyStimulus(vecs[i].sel, vecs[i].inc, 1'b1);
            for (int k = 0; k < 8; k++) begin
                getSample($sformatf("vec%0d_s%0d", i, k), s);
                checkOutput($sformatf("vec%0d_s%0d", i, k), s, int'($signed(vecs[i].exp[k])));
            end
            checkOutput($sformatf("vec%0d_gate", i), int'(gate), 1);
        end

        // Gate latency, then release hold of exactly three samples.
        doReset();
        applyStimulus(2'd1, 24'h100000, 1'b1);
        checkOutput("gate_before_edge", int'(gate), 0);
        stepClock();
        checkOutput("gate_after_rise", int'(gate), 1);
        getSample("rel_s0", s); checkOutput("rel_s0", s, -32768);
        getSample("rel_s1", s); checkOutput("rel_s1", s, -28672);
        note_on = 1'b0;
        checkOutput("gate_before_fall_edge", int'(gate), 1);
        stepClock();
        checkOutput("gate_after_fall", int'(gate), 0);
        getSample("rel_h0", s); checkOutput("rel_h0", s, -24576);
        getSample("rel_h1", s); checkOutput("rel_h1", s, -20480);
        getSample("rel_h2", s); checkOutput("rel_h2", s, -16384);
        getSample("rel_idle0", s); checkOutput("rel_idle0", s, 0);
        getSample("rel_idle1", s); checkOutput("rel_idle1", s, 0);
        checkOutput("rel_idle_gate", int'(gate), 0);
        note_on = 1'b1;
        getSample("rel_restart", s); checkOutput("rel_restart_phase0", s, -32768);

        // Retrigger inside the hold window keeps phase and stays in RUN.
        doReset();
        applyStimulus(2'd1, 24'h100000, 1'b1);
        getSample("rt_s0", s); checkOutput("rt_s0", s, -32768);
        getSample("rt_s1", s); checkOutput("rt_s1", s, -28672);
        note_on = 1'b0;
        stepClock();
        checkOutput("rt_gate_low", int'(gate), 0);
        getSample("rt_h0", s); checkOutput("rt_h0", s, -24576);
        note_on = 1'b1;
        stepClock();
        checkOutput("rt_gate_high", int'(gate), 1);
        for (int k = 0; k < 4; k++) begin
            getSample($sformatf("rt_r%0d", k), s);
            checkOutput($sformatf("rt_r%0d", k), s, -20480 + 4096 * k);
        end
        checkOutput("rt_gate_persist", int'(gate), 1);

        // Saw wrap after 16 samples, then wave_sel/phase_inc taken at tick only.
        doReset();
        applyStimulus(2'd1, 24'h100000, 1'b1);
        for (int k = 0; k < 17; k++) begin
            getSample($sformatf("wrap_s%0d", k), s);
            checkOutput($sformatf("wrap_s%0d", k), s, (k % 16) * 4096 - 32768);
        end
        wave_sel = 2'd0;
        getSample("sel_square", s); checkOutput("sel_square", s, 32767);
        applyStimulus(2'd2, 24'h200000, 1'b1);
        getSample("sel_tri0", s); checkOutput("sel_tri0", s, -16384);
        getSample("sel_tri1", s); checkOutput("sel_tri1", s, 0);
        getSample("sel_tri2", s); checkOutput("sel_tri2", s, 16384);

        // Async reset mid-RUN while out_ready is high, between clock edges.
        checkOutput("pre_reset_ready", int'(out_ready), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_sample", int'(sample_out), 0);
        checkOutput("async_ready", int'(out_ready), 0);
        checkOutput("async_gate", int'(gate), 0);
        note_on = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int c = 1; c <= 3; c++) begin
            stepClock();
            if (out_ready) bad++;
        end
        checkOutput("post_reset_early_ready", bad, 0);
        stepClock();
        checkOutput("post_reset_ready", int'(out_ready), 1);
        checkOutput("post_reset_sample", int'(sample_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
